// File: rtl/pln_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pln_dmem_responder                                           |
// | Description : CPU-side data-memory responder. Serves loads/stores from an  |
// |               on-chip word RAM and decodes an MMIO window holding a TX byte |
// |               FIFO, a STATUS register and an LED register. A store request |
// |               held high across several cycles commits exactly once.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pln_dmem_responder #(
   parameter int          RAM_AW     = 10,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pmem_addr_in,
   input  logic [15:0] pmem_wdata,
   input  logic        pmem_write,
   output logic [15:0] pmem_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [15:0] led
);

   // FIFO pointer and occupancy widths; count needs one extra bit to hold FIFO_DEPTH.
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [15:0]   C_ADDR_TX     = MMIO_BASE;
   localparam logic [15:0]   C_ADDR_STATUS = MMIO_BASE + 16'd1;
   localparam logic [15:0]   C_ADDR_LED    = MMIO_BASE + 16'd2;
   localparam logic [CW-1:0] C_COUNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] C_PTR_ONE     = PW'(1);
   localparam logic [CW-1:0] C_CNT_ONE     = CW'(1);

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [15:0]   ram_q  [0:(1 << RAM_AW) - 1];
   logic [7:0]    fifo_q [0:FIFO_DEPTH - 1];

   logic [15:0]   rdata_q;
   logic [15:0]   led_q,      led_d;
   logic          ovf_q,      ovf_d;
   logic [CW-1:0] count_q,    count_d;
   logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
   logic          prev_write_q;
   logic [15:0]   prev_addr_q;
   logic [15:0]   prev_wdata_q;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic          sel_ram_w;
   logic          sel_tx_w;
   logic          sel_status_w;
   logic          sel_led_w;
   logic [RAM_AW-1:0] ram_idx_w;

   assign sel_ram_w    = ((pmem_addr_in >> RAM_AW) == 16'd0);
   assign sel_tx_w     = (pmem_addr_in == C_ADDR_TX);
   assign sel_status_w = (pmem_addr_in == C_ADDR_STATUS);
   assign sel_led_w    = (pmem_addr_in == C_ADDR_LED);
   assign ram_idx_w    = pmem_addr_in[RAM_AW-1:0];

   // ---------------------------------------------------------------------------
   // Store commit: a held request commits once; a new address or new data
   // during the hold counts as a new store. Nothing commits while in reset.
   // ---------------------------------------------------------------------------
   logic commit_w;

   assign commit_w = ~rst & pmem_write &
                     (~prev_write_q | (pmem_addr_in != prev_addr_q) | (pmem_wdata != prev_wdata_q));

   // ---------------------------------------------------------------------------
   // FIFO status and handshake
   // ---------------------------------------------------------------------------
   logic          empty_w;
   logic          full_w;
   logic          pop_w;
   logic          push_req_w;
   logic          push_ok_w;
   logic          ovf_set_w;
   logic          ovf_clr_w;
   logic [7:0]    head_w;
   logic [15:0]   status_w;

   assign empty_w    = (count_q == '0);
   assign full_w     = (count_q == C_COUNT_FULL);
   assign head_w     = empty_w ? 8'h00 : fifo_q[rd_ptr_q];
   assign pop_w      = ~rst & ~empty_w & tx_ready;
   assign push_req_w = commit_w & sel_tx_w;
   // A pop in the same cycle frees the slot the push needs, so a full FIFO
   // still accepts the byte.
   assign push_ok_w  = push_req_w & (~full_w | pop_w);
   assign ovf_set_w  = push_req_w & full_w & ~pop_w;
   assign ovf_clr_w  = commit_w & sel_status_w & pmem_wdata[15];

   // STATUS image: sticky overflow, full, empty and occupancy count.
   always_comb begin
      status_w         = 16'h0000;
      status_w[15]     = ovf_q;
      status_w[14]     = full_w;
      status_w[13]     = empty_w;
      status_w[CW-1:0] = count_q;
   end

   // Next-state for FIFO pointers, occupancy, overflow flag and LED register.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      led_d    = led_q;

      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (push_ok_w) begin
         wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      end

      case ({push_ok_w, pop_w})
         2'b10:   count_d = count_q + C_CNT_ONE;
         2'b01:   count_d = count_q - C_CNT_ONE;
         default: count_d = count_q;
      endcase

      // An overflow in the same cycle as a clear leaves the flag set.
      if (ovf_set_w) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_w) begin
         ovf_d = 1'b0;
      end

      if (commit_w && sel_led_w) begin
         led_d = pmem_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux: samples the pre-edge state, which gives read-first behaviour
   // when a RAM commit targets the word being read.
   // ---------------------------------------------------------------------------
   logic [15:0] rd_word_w;

   // Select the read word for the current address.
   always_comb begin
      rd_word_w = 16'h0000;
      if (sel_ram_w) begin
         rd_word_w = ram_q[ram_idx_w];
      end else if (sel_tx_w) begin
         rd_word_w = {8'h00, head_w};
      end else if (sel_status_w) begin
         rd_word_w = status_w;
      end else if (sel_led_w) begin
         rd_word_w = led_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------------

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit_w && sel_ram_w) begin
         ram_q[ram_idx_w] <= pmem_wdata;
      end
   end

   // FIFO data slots; stale bytes are hidden by the occupancy count.
   always_ff @(posedge clk) begin
      if (push_ok_w) begin
         fifo_q[wr_ptr_q] <= pmem_wdata[7:0];
      end
   end

   // Control registers, read data and store-edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q      <= 16'h0000;
         led_q        <= 16'h0000;
         ovf_q        <= 1'b0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         prev_write_q <= 1'b0;
         prev_addr_q  <= 16'h0000;
         prev_wdata_q <= 16'h0000;
      end else begin
         rdata_q      <= rd_word_w;
         led_q        <= led_d;
         ovf_q        <= ovf_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         prev_write_q <= pmem_write;
         prev_addr_q  <= pmem_addr_in;
         prev_wdata_q <= pmem_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pmem_rdata = rdata_q;
   assign tx_data    = head_w;
   assign tx_valid   = ~empty_w;
   assign led        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_pln_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pln_dmem_responder                                        |
// | Description : Scoreboard bench for pln_dmem_responder. A queue-based        |
// |               reference model predicts each cycle's outputs; a monitor     |
// |               pops predictions and compares them against the DUT.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pln_dmem_responder;

   localparam logic [15:0] A_TX  = 16'hFF00;
   localparam logic [15:0] A_ST  = 16'hFF01;
   localparam logic [15:0] A_LED = 16'hFF02;
   localparam int          RAM_WORDS = 1024;
   localparam int          DEPTH     = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        write;
   logic        tx_ready;
   logic [15:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic [15:0] led;

   always #5 clk = ~clk;

   pln_dmem_responder #(
      .RAM_AW     (10),
      .FIFO_DEPTH (DEPTH),
      .MMIO_BASE  (16'hFF00)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_addr_in (addr),
      .pmem_wdata   (wdata),
      .pmem_write   (write),
      .pmem_rdata   (rdata),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .led          (led)
   );

   // Expected outputs after one clock edge.
   typedef struct {
      logic [15:0] rdata;
      bit          rd_known;
      bit          tv;
      logic [7:0]  td;
      logic [15:0] led;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state.
   logic [15:0] m_ram   [RAM_WORDS];
   bit          m_known [RAM_WORDS];
   logic [7:0]  m_fifo[$];
   bit          m_ovf;
   logic [15:0] m_led;
   bit          m_pw;
   logic [15:0] m_pa;
   logic [15:0] m_pd;

   function automatic logic [15:0] m_status();
      int n;
      n = m_fifo.size();
      return {m_ovf, (n == DEPTH), (n == 0), 9'd0, 4'(n)};
   endfunction

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_step();
      exp_t e;
      bit   commit;
      bit   pop;
      bit   full_pre;
      e.rd_known = 1'b1;
      e.rdata    = 16'h0000;
      if (rst) begin
         m_fifo.delete();
         m_ovf = 1'b0;
         m_led = 16'h0000;
         m_pw  = 1'b0;
         m_pa  = 16'h0000;
         m_pd  = 16'h0000;
      end else begin
         full_pre = (m_fifo.size() == DEPTH);
         if (int'(addr) < RAM_WORDS) begin
            e.rdata    = m_ram[addr[9:0]];
            e.rd_known = m_known[addr[9:0]];
         end else if (addr == A_TX) begin
            e.rdata = (m_fifo.size() != 0) ? {8'h00, m_fifo[0]} : 16'h0000;
         end else if (addr == A_ST) begin
            e.rdata = m_status();
         end else if (addr == A_LED) begin
            e.rdata = m_led;
         end
         commit = write && (!m_pw || addr != m_pa || wdata != m_pd);
         pop    = (m_fifo.size() != 0) && tx_ready;
         if (pop) void'(m_fifo.pop_front());
         if (commit) begin
            if (int'(addr) < RAM_WORDS) begin
               m_ram[addr[9:0]]   = wdata;
               m_known[addr[9:0]] = 1'b1;
            end else if (addr == A_TX) begin
               if (!full_pre || pop) m_fifo.push_back(wdata[7:0]);
               else                  m_ovf = 1'b1;
            end else if (addr == A_ST) begin
               if (wdata[15]) m_ovf = 1'b0;
            end else if (addr == A_LED) begin
               m_led = wdata;
            end
         end
         m_pw = write;
         m_pa = addr;
         m_pd = wdata;
      end
      e.tv  = (m_fifo.size() != 0);
      e.td  = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
      e.led = m_led;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares each prediction half a cycle after its clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.rd_known) chk("pmem_rdata", rdata, e.rdata);
            chk("tx_valid", {15'd0, tx_valid}, {15'd0, e.tv});
            chk("tx_data",  {8'd0, tx_data},   {8'd0, e.td});
            chk("led",      led,               e.led);
         end
      end
   end

   // Drive one cycle of inputs, then let the model see the edge.
   task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d,
                      input logic w, input logic rdy);
      rst      = r;
      addr     = a;
      wdata    = d;
      write    = w;
      tx_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
   endtask

   logic [15:0] addr_pool [14];

   initial begin
      logic [15:0] ra, rd;
      logic        rw;
      addr_pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h0007, 16'h03FF,
                    16'h0400, 16'h8000, A_TX, A_TX, A_ST, A_LED, 16'hFF03, 16'hFFFF};
      for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;

      // Reset state.
      repeat (3) cyc(1, 16'h0000, 16'h0000, 0, 0);
      cyc(0, A_ST, 16'h0000, 0, 0);

      // Held store commits once; read back one cycle after address applied.
      repeat (6) cyc(0, 16'h0005, 16'hBEEF, 1, 0);
      repeat (2) cyc(0, 16'h0005, 16'h0000, 0, 0);
      // Read-first on a same-address commit.
      cyc(0, 16'h0005, 16'h1111, 1, 0);
      repeat (2) cyc(0, 16'h0005, 16'h0000, 0, 0);

      // Data change mid-hold commits a second push.
      repeat (3) cyc(0, A_TX, 16'h0041, 1, 0);
      repeat (3) cyc(0, A_TX, 16'h0042, 1, 0);
      repeat (2) cyc(0, A_ST, 16'h0000, 0, 0);
      repeat (3) cyc(0, A_ST, 16'h0000, 0, 1);

      // Overfill: nine pushes into an eight-entry FIFO.
      for (int i = 0; i < 9; i++) cyc(0, A_TX, 16'(i), 1, 0);
      repeat (2) cyc(0, A_ST, 16'h0000, 0, 0);

      // Push and pop together while full.
      cyc(0, A_TX, 16'h0055, 1, 1);
      repeat (2) cyc(0, A_ST, 16'h0000, 0, 0);

      // Clear overflow, then program the LED register.
      cyc(0, A_ST, 16'h8000, 1, 0);
      cyc(0, A_ST, 16'h0000, 0, 0);
      cyc(0, A_LED, 16'h00A5, 1, 0);
      repeat (2) cyc(0, A_LED, 16'h0000, 0, 0);
      repeat (10) cyc(0, A_ST, 16'h0000, 0, 1);

      // Reset with bytes queued and a store still held.
      for (int i = 0; i < 3; i++) cyc(0, A_TX, 16'(i + 1), 1, 0);
      repeat (2) cyc(1, A_TX, 16'h0077, 1, 0);
      repeat (3) cyc(0, A_TX, 16'h0077, 1, 0);
      repeat (2) cyc(0, A_ST, 16'h0000, 0, 0);

      // Randomized traffic with frequent holds.
      ra = 16'h0000; rd = 16'h0000; rw = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 45) begin
            ra = addr_pool[$urandom_range(0, 13)];
            rd = 16'($urandom);
            rw = ($urandom_range(0, 2) != 0);
         end
         cyc(($urandom_range(0, 199) == 0), ra, rd, rw, ($urandom_range(0, 99) < 40));
      end

      repeat (2) cyc(0, A_ST, 16'h0000, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
